// File: rtl/lsu_pkg.sv
// Shared definitions for the RV32I load/store unit: funct3 codes, FSM states,
// and the byte-lane helpers used for stores and misalignment detection.
package lsu_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    WB
  } lsu_state_t;

  // Stores only exist in the signed-width encodings (SB/SH/SW).
  function automatic logic f3_ok(input logic st, input logic [2:0] f3);
    if (st) return f3 inside {F3_LB, F3_LH, F3_LW};
    return f3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU};
  endfunction

  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] a);
    case (f3)
      F3_LH, F3_LHU: return a[0];
      F3_LW:         return a != 2'b00;
      default:       return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] byte_strobe(input logic [2:0] f3, input logic [1:0] a);
    case (f3[1:0])
      2'b00:   return 4'b0001 << a;
      2'b01:   return 4'b0011 << {a[1], 1'b0};
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_data(input logic [2:0] f3, input logic [31:0] d);
    case (f3[1:0])
      2'b00:   return {4{d[7:0]}};
      2'b01:   return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Data-memory bus between the load/store unit (master) and memory (slave):
// req/gnt request phase followed by an rvalid read-data phase.
interface load_store_unit_if #(
  parameter int ADDR_W = 32,
  parameter int XLEN   = 32
);

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0]        mem_wstrb;
  logic [XLEN-1:0]   mem_wdata;
  logic              mem_gnt;
  logic              mem_rvalid;
  logic [XLEN-1:0]   mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
    output mem_gnt, mem_rvalid, mem_rdata
  );

endinterface

// File: rtl/lsu_load_align.sv
// Combinational load formatter: picks the byte/half lane out of the read word
// and sign- or zero-extends it according to funct3.
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] value_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = rdata_i[{addr_lo_i, 3'b000} +: 8];
  assign half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];

  always_comb begin
    case (funct3_i)
      F3_LB:   value_o = {{24{byte_sel[7]}}, byte_sel};
      F3_LH:   value_o = {{16{half_sel[15]}}, half_sel};
      F3_LBU:  value_o = {24'h0, byte_sel};
      F3_LHU:  value_o = {16'h0, half_sel};
      default: value_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory stage of the 3-stage RV32I core: one LB/LH/LW/LBU/LHU/SB/SH/SW at a time
// over the req/gnt/rvalid bus. Define LSU_MISALIGN_TRAP_EN to trap misaligned H/W.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int XLEN   = 32
)
(
  input  logic               clock,
  input  logic               reset,
  input  logic               req_valid,
  input  logic               is_store,
  input  logic [2:0]         funct3,
  input  logic [ADDR_W-1:0]  addr,
  input  logic [XLEN-1:0]    st_data,
  input  logic [4:0]         rd_in,
  output logic               lsu_busy,
  load_store_unit_if.master  mem,
  output logic               wb_wen,
  output logic [4:0]         wb_rd,
  output logic [XLEN-1:0]    wb_value,
  output logic               misalign
);

  lsu_state_t        state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [2:0]        f3_q;
  logic [4:0]        rd_q;
  logic              store_q;
  logic [XLEN-1:0]   data_q;
  logic [XLEN-1:0]   value_q;
  logic [XLEN-1:0]   aligned;
  logic              mis_req;
  logic              accept;

`ifdef LSU_MISALIGN_TRAP_EN
  logic misalign_q;

  assign mis_req  = misaligned(funct3, addr[1:0]);
  assign misalign = misalign_q;

  // A trapped request occupies the slot a REQ cycle would have used, then is gone.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) misalign_q <= 1'b0;
    else        misalign_q <= (state_q == IDLE) && req_valid && f3_ok(is_store, funct3) && mis_req;
  end
`else
  assign mis_req  = 1'b0;
  assign misalign = 1'b0;
`endif

  assign accept   = (state_q == IDLE) && req_valid && f3_ok(is_store, funct3) && !mis_req;
  assign lsu_busy = (state_q != IDLE);

  // NOTE: flops use non-blocking assignments so every one samples pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    // NOTE: default first, so paths that do not assign cannot infer a latch.
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = REQ;
      REQ:  if (mem.mem_gnt) state_d = store_q ? IDLE : WAIT;
      WAIT: if (mem.mem_rvalid) state_d = WB;
      WB:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  lsu_load_align u_align (
    .rdata_i   (mem.mem_rdata),
    .addr_lo_i (addr_q[1:0]),
    .funct3_i  (f3_q),
    .value_o   (aligned)
  );

  // NOTE: datapath flops are cleared too, so no output can expose X after reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      addr_q  <= '0;
      f3_q    <= '0;
      rd_q    <= '0;
      store_q <= 1'b0;
      data_q  <= '0;
      value_q <= '0;
    end else begin
      if (accept) begin
        addr_q  <= addr;
        f3_q    <= funct3;
        rd_q    <= rd_in;
        store_q <= is_store;
        data_q  <= st_data;
      end
      if (state_q == WAIT && mem.mem_rvalid) value_q <= aligned;
    end
  end

  // Bus and write-back fields are gated by state so they read 0 when idle.
  always_comb begin
    mem.mem_req   = 1'b0;
    mem.mem_we    = 1'b0;
    mem.mem_addr  = '0;
    mem.mem_wstrb = '0;
    mem.mem_wdata = '0;
    wb_wen        = 1'b0;
    wb_rd         = '0;
    wb_value      = '0;
    case (state_q)
      REQ: begin
        mem.mem_req  = 1'b1;
        mem.mem_we   = store_q;
        mem.mem_addr = {addr_q[ADDR_W-1:2], 2'b00};
        if (store_q) begin
          mem.mem_wstrb = byte_strobe(f3_q, addr_q[1:0]);
          mem.mem_wdata = lane_data(f3_q, data_q);
        end
      end
      WB: begin
        wb_wen   = 1'b1;
        wb_rd    = rd_q;
        wb_value = value_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized scoreboard bench for load_store_unit: a byte-addressed memory model
// predicts bus requests, write-backs and misalign pulses; monitors compare them.
module tb_load_store_unit;
  import lsu_pkg::*;

`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid, is_store;
  logic [2:0]  funct3;
  logic [31:0] addr, st_data;
  logic [4:0]  rd_in;
  logic        lsu_busy, wb_wen, misalign;
  logic [4:0]  wb_rd;
  logic [31:0] wb_value;

  always #5 clock = ~clock;

  load_store_unit_if bus ();

  load_store_unit dut (
    .clock     (clock),
    .reset     (reset),
    .req_valid (req_valid),
    .is_store  (is_store),
    .funct3    (funct3),
    .addr      (addr),
    .st_data   (st_data),
    .rd_in     (rd_in),
    .lsu_busy  (lsu_busy),
    .mem       (bus),
    .wb_wen    (wb_wen),
    .wb_rd     (wb_rd),
    .wb_value  (wb_value),
    .misalign  (misalign)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  strb;
    logic [31:0] wdata;
  } bus_exp_t;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] val;
  } wb_exp_t;

  bus_exp_t   exp_bus_q[$];
  wb_exp_t    exp_wb_q[$];
  int         exp_mis = 0;
  logic [7:0] model_mem [logic [31:0]];
  int         gnt_dly = 0;
  int         rv_dly  = 1;
  int         tests   = 0;
  int         fails   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] mbyte(input logic [31:0] a);
    if (model_mem.exists(a)) return model_mem[a];
    return a[7:0] ^ 8'h5A;
  endfunction

  function automatic logic [31:0] mword(input logic [31:0] a);
    logic [31:0] w;
    for (int i = 0; i < 4; i++) w[8*i +: 8] = mbyte({a[31:2], 2'b00} + i);
    return w;
  endfunction

  task automatic check_zero(input string tag);
    check({tag, "_ctl"}, {lsu_busy, bus.mem_req, bus.mem_we, bus.mem_wstrb, wb_wen, wb_rd, misalign}, 0);
    check({tag, "_addr"}, bus.mem_addr, 0);
    check({tag, "_wdata"}, bus.mem_wdata, 0);
    check({tag, "_wbval"}, wb_value, 0);
  endtask

  // Predict the op from byte-level memory semantics, drive it, then time the stall.
  task automatic issue(input bit st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] d, input logic [4:0] rd, input bit do_wait);
    bit          valid, mis;
    int          size, busy_exp, busy_cnt;
    logic [31:0] base, v;
    logic [3:0]  strb;
    bus_exp_t    be;
    wb_exp_t     we_;
    valid    = st ? (f3 inside {F3_LB, F3_LH, F3_LW})
                  : (f3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU});
    size     = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    mis      = TRAP && ((a % size) != 0);
    base     = a - (a % size);
    busy_exp = 0;
    if (valid && mis) begin
      exp_mis++;
    end else if (valid && st) begin
      strb = '0;
      for (int i = 0; i < size; i++) begin
        strb[(base + i) % 4] = 1'b1;
        model_mem[base + i]  = d[8*i +: 8];
      end
      be.we    = 1'b1;
      be.addr  = {a[31:2], 2'b00};
      be.strb  = strb;
      be.wdata = (size == 1) ? {4{d[7:0]}} : (size == 2) ? {2{d[15:0]}} : d;
      exp_bus_q.push_back(be);
      busy_exp = gnt_dly + 1;
    end else if (valid) begin
      v = '0;
      for (int i = 0; i < size; i++) v[8*i +: 8] = mbyte(base + i);
      if (f3 == F3_LB) v = {{24{v[7]}}, v[7:0]};
      if (f3 == F3_LH) v = {{16{v[15]}}, v[15:0]};
      be.we    = 1'b0;
      be.addr  = {a[31:2], 2'b00};
      be.strb  = '0;
      be.wdata = '0;
      exp_bus_q.push_back(be);
      if (do_wait) begin
        we_.rd  = rd;
        we_.val = v;
        exp_wb_q.push_back(we_);
      end
      busy_exp = gnt_dly + 1 + rv_dly + 1;
    end
    @(negedge clock);
    req_valid = 1'b1;
    is_store  = st;
    funct3    = f3;
    addr      = a;
    st_data   = d;
    rd_in     = rd;
    @(negedge clock);
    req_valid = 1'b0;
    addr      = $urandom;
    st_data   = $urandom;
    if (do_wait) begin
      busy_cnt = 0;
      for (int i = 0; i < 64 && lsu_busy === 1'b1; i++) begin
        busy_cnt++;
        @(negedge clock);
      end
      check("busy_cycles", busy_cnt, busy_exp);
      check("busy_release", lsu_busy, 0);
      @(negedge clock);
    end
  endtask

  // Memory slave: programmable grant and read latency, spurious gnt/rvalid when idle.
  initial begin : responder
    int          cnt;
    int          rcnt;
    bit          rd_pend;
    logic [31:0] raddr;
    bus_exp_t    e;
    cnt = 0; rcnt = 0; rd_pend = 0; raddr = '0;
    bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
    forever begin
      @(negedge clock);
      bus.mem_gnt    = 1'b0;
      bus.mem_rvalid = 1'b0;
      bus.mem_rdata  = $urandom;
      if (rd_pend) begin
        if (rcnt == 0) begin
          bus.mem_rvalid = 1'b1;
          bus.mem_rdata  = mword(raddr);
          rd_pend        = 1'b0;
        end else begin
          rcnt--;
        end
      end else if (bus.mem_req === 1'b1) begin
        if (cnt >= gnt_dly) begin
          bus.mem_gnt = 1'b1;
          cnt = 0;
          if (exp_bus_q.size() == 0) begin
            check("bus_unexpected", 1, 0);
          end else begin
            e = exp_bus_q.pop_front();
            check("bus_we", bus.mem_we, e.we);
            check("bus_addr", bus.mem_addr, e.addr);
            if (e.we) begin
              check("bus_wstrb", bus.mem_wstrb, e.strb);
              check("bus_wdata", bus.mem_wdata, e.wdata);
            end else begin
              rd_pend = 1'b1;
              rcnt    = rv_dly - 1;
              raddr   = bus.mem_addr;
            end
          end
        end else begin
          cnt++;
        end
      end else if ($urandom_range(0, 3) == 0) begin
        bus.mem_gnt    = 1'b1;
        bus.mem_rvalid = 1'b1;
      end
    end
  end

  initial begin : wb_monitor
    wb_exp_t w;
    forever begin
      @(negedge clock);
      if (wb_wen === 1'b1) begin
        if (exp_wb_q.size() == 0) begin
          check("wb_unexpected", 1, 0);
        end else begin
          w = exp_wb_q.pop_front();
          check("wb_rd", wb_rd, w.rd);
          check("wb_value", wb_value, w.val);
        end
      end
    end
  end

  initial begin : mis_monitor
    forever begin
      @(negedge clock);
      if (misalign === 1'b1) begin
        check("misalign_expected", exp_mis > 0, 1);
        if (exp_mis > 0) exp_mis--;
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "simulation did not finish");
  end

  initial begin : main
    bit          st;
    logic [2:0]  f3;
    logic [2:0]  st_f3 [3];
    logic [2:0]  ld_f3 [8];
    reset = 1'b0; req_valid = 1'b0; is_store = 1'b0; funct3 = '0;
    addr = '0; st_data = '0; rd_in = '0;
    st_f3 = '{F3_LB, F3_LH, F3_LW};
    ld_f3 = '{F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU, 3'b011, 3'b110, 3'b111};
    repeat (2) @(negedge clock);
    check_zero("reset");
    reset = 1'b1;

    model_mem[32'h100] = 8'hEF; model_mem[32'h101] = 8'hBE;
    model_mem[32'h102] = 8'hAD; model_mem[32'h103] = 8'hDE;
    gnt_dly = 0; rv_dly = 1;
    issue(1'b0, F3_LW, 32'h100, 32'h0, 5'd7, 1'b1);
    model_mem[32'h102] = 8'h01; model_mem[32'h103] = 8'h80;
    issue(1'b0, F3_LB,  32'h103, 32'h0, 5'd3, 1'b1);
    issue(1'b0, F3_LBU, 32'h103, 32'h0, 5'd4, 1'b1);
    issue(1'b0, F3_LH,  32'h102, 32'h0, 5'd5, 1'b1);
    issue(1'b1, F3_LB,  32'h101, 32'h0000_00AB, 5'd9, 1'b1);
    gnt_dly = 3; rv_dly = 2;
    issue(1'b0, F3_LW, 32'h104, 32'h0, 5'd12, 1'b1);
    gnt_dly = 0; rv_dly = 1;
    issue(1'b0, F3_LW, 32'h102, 32'h0, 5'd13, 1'b1);
    issue(1'b0, F3_LW, 32'h100, 32'h0, 5'd0, 1'b1);
    issue(1'b0, 3'b011, 32'h100, 32'h0, 5'd1, 1'b1);
    issue(1'b1, 3'b110, 32'h100, 32'h1234_5678, 5'd1, 1'b1);
    issue(1'b1, F3_LBU, 32'h100, 32'h1234_5678, 5'd1, 1'b1);

    // Reset while the load sits in WAIT; the late rvalid must be ignored.
    rv_dly = 5;
    issue(1'b0, F3_LW, 32'h108, 32'h0, 5'd20, 1'b0);
    @(negedge clock);
    #2 reset = 1'b0;
    #1 check_zero("mid_reset");
    @(negedge clock);
    reset = 1'b1;
    repeat (8) @(negedge clock);
    check("idle_after_reset", lsu_busy, 0);

    for (int n = 0; n < 300; n++) begin
      st      = $urandom_range(0, 2) == 0;
      f3      = st ? st_f3[$urandom_range(0, 2)] : ld_f3[$urandom_range(0, 7)];
      gnt_dly = $urandom_range(0, 3);
      rv_dly  = $urandom_range(1, 3);
      issue(st, f3, 32'h100 + $urandom_range(0, 63), $urandom, 5'($urandom), 1'b1);
    end

    repeat (10) @(negedge clock);
    check("bus_q_drained", exp_bus_q.size(), 0);
    check("wb_q_drained", exp_wb_q.size(), 0);
    check("misalign_drained", exp_mis, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
